modinv_helper_invert_update: RTL and testbench



---
 rtl/modinv_helper_invert_update.sv | 158 +++++++++++++++
 tb/tb_modinv_helper_invert_update.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/modinv_helper_invert_update.sv
// One Kaliski almost-inverse step: pick a branch from the parity and sign
// of u, v and v-u, then copy the precalc candidates into r, s, u, v.
module modinv_helper_invert_update #(
  parameter int BUFFER_NUM_WORDS = 9,
  parameter int BUFFER_ADDR_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  output logic                        rdy,
  output logic                        v_zero,
  output logic [1:0]                  branch,
  output logic [BUFFER_ADDR_BITS-1:0] src_addr,
  input  logic [31:0]                 u_din,
  input  logic [31:0]                 v_din,
  input  logic [31:0]                 v_minus_u_din,
  input  logic [31:0]                 u_half_din,
  input  logic [31:0]                 v_half_din,
  input  logic [31:0]                 u_minus_v_half_din,
  input  logic [31:0]                 v_minus_u_half_din,
  input  logic [31:0]                 r_dbl_din,
  input  logic [31:0]                 s_dbl_din,
  input  logic [31:0]                 r_plus_s_din,
  output logic [BUFFER_ADDR_BITS-1:0] dst_addr,
  output logic                        r_wren,
  output logic                        s_wren,
  output logic                        u_wren,
  output logic                        v_wren,
  output logic [31:0]                 r_dout,
  output logic [31:0]                 s_dout,
  output logic [31:0]                 u_dout,
  output logic [31:0]                 v_dout
);

  localparam int N  = BUFFER_NUM_WORDS;
  localparam int CW = $clog2(N + 4);
  localparam int AW = BUFFER_ADDR_BITS;
  localparam logic [CW-1:0] C_LAST = CW'(N + 3);

  typedef enum logic [1:0] {
    BR_A = 2'd0,
    BR_B = 2'd1,
    BR_C = 2'd2,
    BR_D = 2'd3
  } br_e;

  logic [CW-1:0] r_cnt;
  logic          r_u_lsb;
  logic          r_v_lsb;
  br_e           r_sel;
  br_e           w_sel;
  logic [1:0]    r_branch;
  logic          r_vor;
  logic          r_v_zero;
  logic          w_copy;
  logic [31:0]   w_new_v;

  assign rdy    = (r_cnt == '0);
  assign w_copy = (r_cnt >= CW'(4));
  assign v_zero = r_v_zero;
  assign branch = r_branch;

  // word N-1 is fetched early so the sign of v-u is known before the copy
  always_comb begin
    src_addr = '0;
    if (r_cnt == CW'(2))
      src_addr = AW'(N - 1);
    else if (r_cnt >= CW'(3) && r_cnt <= CW'(N + 2))
      src_addr = AW'(r_cnt - CW'(3));
  end

  assign dst_addr = w_copy ? AW'(r_cnt - CW'(4)) : '0;

  always_comb begin
    w_sel = BR_D;
    unique case (1'b1)
      !r_u_lsb:                                 w_sel = BR_A;
      r_u_lsb && !r_v_lsb:                      w_sel = BR_B;
      r_u_lsb && r_v_lsb && v_minus_u_din[31]:  w_sel = BR_C;
      default:                                  w_sel = BR_D;
    endcase
  end

  always_comb begin
    u_wren  = 1'b0;
    v_wren  = 1'b0;
    r_wren  = 1'b0;
    s_wren  = 1'b0;
    u_dout  = u_half_din;
    v_dout  = v_half_din;
    r_dout  = r_dbl_din;
    s_dout  = s_dbl_din;
    w_new_v = v_din;
    unique case (r_sel)
      BR_A: begin
        u_wren = w_copy;
        s_wren = w_copy;
      end
      BR_B: begin
        v_wren  = w_copy;
        r_wren  = w_copy;
        w_new_v = v_half_din;
      end
      BR_C: begin
        u_wren = w_copy;
        r_wren = w_copy;
        s_wren = w_copy;
        u_dout = u_minus_v_half_din;
        r_dout = r_plus_s_din;
      end
      BR_D: begin
        v_wren  = w_copy;
        r_wren  = w_copy;
        s_wren  = w_copy;
        v_dout  = v_minus_u_half_din;
        s_dout  = r_plus_s_din;
        w_new_v = v_minus_u_half_din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_u_lsb  <= 1'b0;
      r_v_lsb  <= 1'b0;
      r_sel    <= BR_A;
      r_branch <= 2'd0;
      r_vor    <= 1'b0;
      r_v_zero <= 1'b0;
    end else begin
      if (rdy) begin
        if (ena)
          r_cnt <= CW'(1);
      end else if (r_cnt == C_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_cnt == CW'(2)) begin
        r_u_lsb <= u_din[0];
        r_v_lsb <= v_din[0];
      end
      if (r_cnt == CW'(3)) begin
        r_sel <= w_sel;
        r_vor <= 1'b0;
      end
      if (w_copy)
        r_vor <= r_vor | (|w_new_v);
      if (r_cnt == C_LAST) begin
        r_v_zero <= ~(r_vor | (|w_new_v));
        r_branch <= r_sel;
      end
    end
  end

endmodule

// File: tb/tb_modinv_helper_invert_update.sv
// Bench for modinv_helper_invert_update: table vectors, corner sequences
// and random operands checked against a big-integer step model.
module tb_modinv_helper_invert_update;

  localparam int N  = 9;
  localparam int AW = 4;
  typedef logic [32*N-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          rdy;
  logic          v_zero;
  logic [1:0]    branch;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic          r_wren, s_wren, u_wren, v_wren;
  logic [31:0]   r_dout, s_dout, u_dout, v_dout;
  logic [31:0]   u_din, v_din, v_minus_u_din;
  logic [31:0]   u_half_din, v_half_din;
  logic [31:0]   u_minus_v_half_din, v_minus_u_half_din;
  logic [31:0]   r_dbl_din, s_dbl_din, r_plus_s_din;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  modinv_helper_invert_update #(
    .BUFFER_NUM_WORDS(N),
    .BUFFER_ADDR_BITS(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rdy(rdy),
    .v_zero(v_zero), .branch(branch), .src_addr(src_addr),
    .u_din(u_din), .v_din(v_din), .v_minus_u_din(v_minus_u_din),
    .u_half_din(u_half_din), .v_half_din(v_half_din),
    .u_minus_v_half_din(u_minus_v_half_din),
    .v_minus_u_half_din(v_minus_u_half_din),
    .r_dbl_din(r_dbl_din), .s_dbl_din(s_dbl_din),
    .r_plus_s_din(r_plus_s_din), .dst_addr(dst_addr),
    .r_wren(r_wren), .s_wren(s_wren), .u_wren(u_wren), .v_wren(v_wren),
    .r_dout(r_dout), .s_dout(s_dout), .u_dout(u_dout), .v_dout(v_dout)
  );

  // buffer model: working r/s/u/v plus precalc candidates, sync read
  logic [31:0] um[16], vm[16], rm[16], sm[16];
  logic [31:0] vmu[16], uh[16], vh[16], umvh[16], vmuh[16];
  logic [31:0] rd[16], sd[16], rps[16];
  logic ld = 1'b0;
  vec_t ld_u, ld_v, ld_r, ld_s;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < N; i++) begin
        um[i]   <= ld_u[32*i +: 32];
        vm[i]   <= ld_v[32*i +: 32];
        rm[i]   <= ld_r[32*i +: 32];
        sm[i]   <= ld_s[32*i +: 32];
        vmu[i]  <= (ld_v - ld_u) >> (32*i);
        uh[i]   <= (ld_u >> 1) >> (32*i);
        vh[i]   <= (ld_v >> 1) >> (32*i);
        umvh[i] <= ((ld_u - ld_v) >> 1) >> (32*i);
        vmuh[i] <= ((ld_v - ld_u) >> 1) >> (32*i);
        rd[i]   <= (ld_r << 1) >> (32*i);
        sd[i]   <= (ld_s << 1) >> (32*i);
        rps[i]  <= (ld_r + ld_s) >> (32*i);
      end
    end else begin
      if (u_wren) um[dst_addr] <= u_dout;
      if (v_wren) vm[dst_addr] <= v_dout;
      if (r_wren) rm[dst_addr] <= r_dout;
      if (s_wren) sm[dst_addr] <= s_dout;
    end
    u_din              <= um[src_addr];
    v_din              <= vm[src_addr];
    v_minus_u_din      <= vmu[src_addr];
    u_half_din         <= uh[src_addr];
    v_half_din         <= vh[src_addr];
    u_minus_v_half_din <= umvh[src_addr];
    v_minus_u_half_din <= vmuh[src_addr];
    r_dbl_din          <= rd[src_addr];
    s_dbl_din          <= sd[src_addr];
    r_plus_s_din       <= rps[src_addr];
  end

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // reference: one almost-inverse step on whole integers
  function automatic void ref_step(
    input vec_t u, input vec_t v, input vec_t r, input vec_t s,
    output logic [1:0] br, output vec_t nu, output vec_t nv,
    output vec_t nr, output vec_t ns, output logic vz);
    nu = u; nv = v; nr = r; ns = s;
    if (u[0] == 1'b0) begin
      br = 2'd0; nu = u / 2; ns = s * 2;
    end else if (v[0] == 1'b0) begin
      br = 2'd1; nv = v / 2; nr = r * 2;
    end else if (u > v) begin
      br = 2'd2; nu = (u - v) / 2; nr = r + s; ns = s * 2;
    end else begin
      br = 2'd3; nv = (v - u) / 2; ns = r + s; nr = r * 2;
    end
    vz = (nv == '0);
  endfunction

  function automatic vec_t gather(input logic [31:0] m[16]);
    vec_t x;
    for (int i = 0; i < N; i++) x[32*i +: 32] = m[i];
    return x;
  endfunction

  // called on a falling edge with rdy=1; returns on the first rdy=1 fall
  task automatic run_step(
    input vec_t u, input vec_t v, input vec_t r, input vec_t s,
    input int pulse_at,
    output logic [1:0] br, output vec_t nu, output vec_t nv,
    output vec_t nr, output vec_t ns, output logic vz,
    output int busy, output int cu, output int cv,
    output int cr, output int cs, output int bad_addr);
    ld_u = u; ld_v = v; ld_r = r; ld_s = s;
    ld = 1'b1; ena = 1'b1;
    @(negedge clk);
    ld = 1'b0; ena = 1'b0;
    busy = 0; cu = 0; cv = 0; cr = 0; cs = 0; bad_addr = 0;
    while (!rdy && busy < 100) begin
      busy++;
      cu += int'(u_wren);
      cv += int'(v_wren);
      cr += int'(r_wren);
      cs += int'(s_wren);
      if (src_addr > AW'(N - 1) || dst_addr > AW'(N - 1)) bad_addr++;
      ena = (busy == pulse_at);
      @(negedge clk);
    end
    ena = 1'b0;
    br = branch; vz = v_zero;
    nu = gather(um); nv = gather(vm); nr = gather(rm); ns = gather(sm);
  endtask

  task automatic step_and_check(
    input string tag, input vec_t u, input vec_t v,
    input vec_t r, input vec_t s, input int pulse_at);
    logic [1:0] br, ebr;
    vec_t nu, nv, nr, ns, eu, ev, er, es;
    logic vz, evz;
    int busy, cu, cv, cr, cs, bad;
    ref_step(u, v, r, s, ebr, eu, ev, er, es, evz);
    run_step(u, v, r, s, pulse_at, br, nu, nv, nr, ns, vz,
             busy, cu, cv, cr, cs, bad);
    chk({tag, " branch"}, vec_t'(br), vec_t'(ebr));
    chk({tag, " u"}, nu, eu);
    chk({tag, " v"}, nv, ev);
    chk({tag, " r"}, nr, er);
    chk({tag, " s"}, ns, es);
    chk({tag, " v_zero"}, vec_t'(vz), vec_t'(evz));
    chk({tag, " busy"}, vec_t'(busy), vec_t'(N + 3));
    chk({tag, " u_wren_cnt"}, vec_t'(cu), vec_t'((ebr == 0 || ebr == 2) ? N : 0));
    chk({tag, " v_wren_cnt"}, vec_t'(cv), vec_t'((ebr == 1 || ebr == 3) ? N : 0));
    chk({tag, " r_wren_cnt"}, vec_t'(cr), vec_t'((ebr != 0) ? N : 0));
    chk({tag, " s_wren_cnt"}, vec_t'(cs), vec_t'((ebr != 1) ? N : 0));
    chk({tag, " addr_range"}, vec_t'(bad), '0);
  endtask

  typedef struct {
    vec_t u, v, r, s;
    logic [1:0] br;
    vec_t eu, ev, er, es;
    logic vz;
  } rec_t;

  function automatic vec_t rand_vec(input int drop);
    vec_t x;
    for (int i = 0; i < N; i++) x[32*i +: 32] = $urandom;
    return x >> drop;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t tbl[8];
    vec_t p224;
    logic [1:0] br;
    vec_t nu, nv, nr, ns;
    logic vz;
    int busy, cu, cv, cr, cs, bad;

    p224 = vec_t'(1) << 224;
    tbl[0] = '{u:12, v:5, r:1, s:3, br:0, eu:6, ev:5, er:1, es:6, vz:0};
    tbl[1] = '{u:7, v:4, r:2, s:1, br:1, eu:7, ev:2, er:4, es:1, vz:0};
    tbl[2] = '{u:9, v:5, r:1, s:2, br:2, eu:2, ev:5, er:3, es:4, vz:0};
    tbl[3] = '{u:5, v:9, r:1, s:2, br:3, eu:5, ev:2, er:2, es:3, vz:0};
    tbl[4] = '{u:7, v:7, r:1, s:2, br:3, eu:7, ev:0, er:2, es:3, vz:1};
    tbl[5] = '{u:p224 + 1, v:p224 - 1, r:1, s:1, br:2,
               eu:1, ev:p224 - 1, er:2, es:2, vz:0};
    tbl[6] = '{u:p224 - 1, v:p224 + 1, r:1, s:1, br:3,
               eu:p224 - 1, ev:1, er:2, es:2, vz:0};
    tbl[7] = '{u:4, v:6, r:1, s:1, br:0, eu:2, ev:6, er:1, es:2, vz:0};

    repeat (3) @(negedge clk);
    chk("reset rdy", vec_t'(rdy), vec_t'(1));
    chk("reset v_zero", vec_t'(v_zero), '0);
    chk("reset branch", vec_t'(branch), '0);
    chk("reset addr", vec_t'({src_addr, dst_addr}), '0);
    chk("reset wren", vec_t'({u_wren, v_wren, r_wren, s_wren}), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // table vectors, launched back to back on the first rdy cycle
    foreach (tbl[k]) begin
      run_step(tbl[k].u, tbl[k].v, tbl[k].r, tbl[k].s, 0,
               br, nu, nv, nr, ns, vz, busy, cu, cv, cr, cs, bad);
      chk($sformatf("tbl%0d branch", k), vec_t'(br), vec_t'(tbl[k].br));
      chk($sformatf("tbl%0d u", k), nu, tbl[k].eu);
      chk($sformatf("tbl%0d v", k), nv, tbl[k].ev);
      chk($sformatf("tbl%0d r", k), nr, tbl[k].er);
      chk($sformatf("tbl%0d s", k), ns, tbl[k].es);
      chk($sformatf("tbl%0d v_zero", k), vec_t'(vz), vec_t'(tbl[k].vz));
      chk($sformatf("tbl%0d busy", k), vec_t'(busy), vec_t'(12));
    end
    chk("tbl0-last wren rule", vec_t'(bad), '0);

    // ena pulsed mid-step must not change the step
    step_and_check("ena_busy", 12, 5, 1, 3, 5);
    chk("ena_busy idle after", vec_t'(rdy), vec_t'(1));

    // leave branch=3, v_zero=1 so the abort visibly clears them
    step_and_check("pre_reset", 7, 7, 1, 2, 0);
    ld_u = 12; ld_v = 5; ld_r = 1; ld_s = 3;
    ld = 1'b1; ena = 1'b1;
    @(negedge clk);
    ld = 1'b0; ena = 1'b0;
    repeat (5) @(negedge clk);
    chk("c6 u_wren", vec_t'(u_wren), vec_t'(1));
    chk("c6 dst_addr", vec_t'(dst_addr), vec_t'(2));
    rst_n = 1'b0;
    #1;
    chk("abort rdy", vec_t'(rdy), vec_t'(1));
    chk("abort wren", vec_t'({u_wren, v_wren, r_wren, s_wren}), '0);
    chk("abort branch", vec_t'(branch), '0);
    chk("abort v_zero", vec_t'(v_zero), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step_and_check("post_reset", 9, 5, 1, 2, 0);

    for (int t = 0; t < 24; t++) begin
      vec_t u, v, r, s;
      int m;
      m = int'($urandom_range(0, 3));
      u = rand_vec(1 + int'($urandom_range(0, 3)) * 60);
      v = rand_vec(1 + int'($urandom_range(0, 3)) * 60);
      r = rand_vec(2 + int'($urandom_range(0, 200)));
      s = rand_vec(2 + int'($urandom_range(0, 200)));
      if (m == 0) v = u;
      if (m == 1) v = u ^ vec_t'($urandom_range(0, 255));
      u[0] = ($urandom_range(0, 3) != 0);
      v[0] = ($urandom_range(0, 3) != 0);
      step_and_check($sformatf("rnd%0d", t), u, v, r, s, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
